// File: rtl/barrett_precomp.sv
// Barrett precomputation: computes the bitlength k of modulus m and mu = floor(2^(2k)/m)
// with a one-bit-per-cycle restoring divider.
module barrett_precomp #(
  parameter int unsigned DATA_LENGTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic                   error_o,
  output logic [DATA_LENGTH-1:0] m_bl_o,
  output logic [DATA_LENGTH-1:0] mu_o
);

  localparam int unsigned KW = $clog2(DATA_LENGTH + 1);
  localparam int unsigned CW = KW + 1;

  typedef enum logic [1:0] {StIdle, StScan, StDivide, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_LENGTH-1:0] m_q, rem_q, quot_q, mu_q, m_bl_q;
  logic [KW-1:0]          k_q, k_scan;
  logic [CW-1:0]          cnt_q;
  logic                   err_q;

  logic                   m_bad;
  logic                   nbit;
  logic                   q_bit;
  logic [DATA_LENGTH:0]   rem_sh;
  logic [DATA_LENGTH-1:0] rem_lo, rem_nx, rem_d, quot_d;

  // Bitlength: index of the most-significant set bit plus one.
  always_comb begin
    k_scan = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (m_q[i]) k_scan = KW'(i + 1);
    end
  end

  assign m_bad = (m_q == '0) || (m_q[DATA_LENGTH-1:DATA_LENGTH-2] != 2'b00);

  // N = 2^(2k) has a single set bit, the first one fed in.
  assign nbit   = (cnt_q == {k_q, 1'b0});
  assign rem_sh = {rem_q, nbit};
  assign rem_lo = {rem_q[DATA_LENGTH-2:0], nbit};
  assign q_bit  = (rem_sh >= {1'b0, m_q});
  // The true difference is below m_q, so the low bits alone are exact.
  assign rem_nx = rem_lo - m_q;
  assign rem_d  = q_bit ? rem_nx : rem_lo;
  assign quot_d = (quot_q << 1) | {{(DATA_LENGTH-1){1'b0}}, q_bit};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start_i) state_d = StScan;
      StScan:   state_d = m_bad ? StDone : StDivide;
      StDivide: if (cnt_q == '0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q    <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      mu_q   <= '0;
      m_bl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) m_q <= m_i;
        end
        StScan: begin
          k_q    <= k_scan;
          cnt_q  <= {k_scan, 1'b0};
          rem_q  <= '0;
          quot_q <= '0;
          if (m_bad) begin
            mu_q   <= '0;
            m_bl_q <= '0;
            err_q  <= 1'b1;
          end
        end
        StDivide: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            mu_q   <= quot_d;
            m_bl_q <= {{(DATA_LENGTH-KW){1'b0}}, k_q};
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state_q == StScan) || (state_q == StDivide);
  assign valid_o = (state_q == StDone);
  assign error_o = err_q;
  assign m_bl_o  = m_bl_q;
  assign mu_o    = mu_q;

endmodule

// File: tb/tb_barrett_precomp.sv
// Randomized self-checking bench for barrett_precomp against a wide-arithmetic reference model.
module tb_barrett_precomp;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [63:0] m_i;
  logic        busy_o, valid_o, error_o;
  logic [63:0] m_bl_o, mu_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] prev_mu = '0;

  barrett_precomp #(.DATA_LENGTH(64)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .m_i     (m_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .error_o (error_o),
    .m_bl_o  (m_bl_o),
    .mu_o    (mu_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_k(input logic [63:0] m);
    int k = 0;
    while (k < 64 && (m >> k) != 64'd0) k++;
    return k;
  endfunction

  function automatic logic [63:0] ref_mu(input logic [63:0] m, input int k);
    logic [255:0] n, q;
    n = 256'd1 << (2 * k);
    q = n / {192'd0, m};
    return q[63:0];
  endfunction

  // Precondition: called #1 after a rising edge with the DUT idle.
  task automatic do_op(input logic [63:0] m, input bit noise, input string tag);
    logic [63:0] exp_mu, exp_bl;
    bit          bad, got;
    int          k, lat, busy_cnt, exp_lat;
    bad     = (m == 64'd0) || (m[63:62] != 2'b00);
    k       = ref_k(m);
    exp_mu  = bad ? 64'd0 : ref_mu(m, k);
    exp_bl  = bad ? 64'd0 : 64'(k);
    exp_lat = bad ? 2 : 2 * k + 3;
    start_i = 1'b1;
    m_i     = m;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    got      = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (valid_o) begin
        got = 1'b1;
        break;
      end
      if (busy_o) busy_cnt++;
      check({tag, " mu hold"}, mu_o, prev_mu);
      if (noise) begin
        m_i     = {$urandom, $urandom};
        start_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk_i); #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, " completed"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, " busy in done"}, 64'(busy_o), 64'd0);
    check({tag, " mu"}, mu_o, exp_mu);
    check({tag, " m_bl"}, m_bl_o, exp_bl);
    check({tag, " error"}, 64'(error_o), 64'(bad));
    prev_mu = exp_mu;
    @(posedge clk_i); #1;
    check({tag, " valid one cycle"}, 64'(valid_o), 64'd0);
    check({tag, " mu after done"}, mu_o, exp_mu);
  endtask

  initial begin
    logic [63:0] m, mask;
    int          k;
    bit          seen;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    m_i     = '0;
    #2;
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset valid", 64'(valid_o), 64'd0);
    check("reset mu", mu_o, 64'd0);
    check("reset m_bl", m_bl_o, 64'd0);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    do_op(64'd13, 1'b0, "m13");
    do_op(64'd1, 1'b0, "m1");
    do_op(64'h2000_0000_0000_0000, 1'b0, "m2p61");
    do_op(64'h3fff_ffff_ffff_ffff, 1'b0, "m2p62m1");
    do_op(64'd0, 1'b0, "m0");
    do_op(64'h4000_0000_0000_0000, 1'b0, "m2p62");

    // Abort mid-divide; error_o is still 1 from the previous rejection.
    start_i = 1'b1;
    m_i     = 64'd13;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) begin
      @(posedge clk_i); #1;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check("async busy", 64'(busy_o), 64'd0);
    check("async valid", 64'(valid_o), 64'd0);
    check("async error", 64'(error_o), 64'd0);
    check("async m_bl", m_bl_o, 64'd0);
    check("async mu", mu_o, 64'd0);
    #1;
    rst_ni  = 1'b1;
    prev_mu = '0;
    seen    = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk_i); #1;
      if (valid_o || busy_o) seen = 1'b1;
    end
    check("no aborted result", 64'(seen), 64'd0);
    do_op(64'd7, 1'b0, "m7 after reset");

    do_op(64'd13, 1'b1, "m13 noisy");
    do_op(64'd5, 1'b1, "m5 back2back");

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 7))
        0: m = 64'd0;
        1: m = {2'b01 + 2'($urandom_range(0, 2)), 62'($urandom)};
        default: begin
          k    = $urandom_range(1, 62);
          mask = (64'd1 << k) - 64'd1;
          m    = ({$urandom, $urandom} & mask) | (64'd1 << (k - 1));
        end
      endcase
      do_op(m, 1'($urandom_range(0, 1)), $sformatf("rand%0d m=0x%0h", i, m));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/barrett_precomp.md
BARRETT_PRECOMP -- requirements
Module: barrett_precomp

Interface
REQ-001 Parameter: DATA_LENGTH, default from multiplier_pkg (64), operand/result word width.
REQ-002 Port: clk_i  input  1  rising-edge clock; the block has one clock.
REQ-003 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port: start_i  input  1  request; sampled only in IDLE.
REQ-005 Port: m_i  input  DATA_LENGTH  modulus; captured on the accepted start.
REQ-006 Port: busy_o  output  1  high in SCAN and DIVIDE.
REQ-007 Port: valid_o  output  1  one-cycle completion pulse, high in DONE only.
REQ-008 Port: error_o  output  1  modulus rejected; valid with valid_o and held until the next completion.
REQ-009 Port: m_bl_o  output  DATA_LENGTH  bitlength k of the captured modulus, zero-extended.
REQ-010 Port: mu_o  output  DATA_LENGTH  floor(2^(2k)/m); feeds the Barrett reducer's mu and m_bl inputs.

Function
REQ-011 The FSM SHALL have four states: IDLE, SCAN, DIVIDE and DONE.
REQ-012 IDLE with start_i=1: capture m_i into m_q; next state SCAN. start_i in any other state SHALL be ignored.
REQ-013 SCAN lasts one cycle.
  - k = index of the most-significant set bit of m_q plus 1.
  - Error when m_q==0 or m_q[DATA_LENGTH-1:DATA_LENGTH-2]!=0.
  - Error: next state DONE. Otherwise load the iteration counter with 2k and go to DIVIDE.
REQ-014 DIVIDE SHALL run a restoring division of N=2^(2k) by m_q, one dividend bit per cycle, bits 2k down to 0, for exactly 2k+1 cycles.
  - rem' = {rem,Nbit}.
  - If rem' >= m_q: rem' -= m_q and the quotient bit is 1.
  - Quotient shifts in at the LSB.
REQ-015 The remainder register SHALL be DATA_LENGTH bits wide. The compare/subtract SHALL be DATA_LENGTH+1 bits wide so there is no overflow at k=DATA_LENGTH-2.
REQ-016 When the counter reaches 0 in DIVIDE, the next state SHALL be DONE.
REQ-017 On entry to DONE, the block SHALL register m_bl_o, mu_o and error_o.
  - Success: m_bl_o=k, mu_o=quotient, error_o=0.
  - Error: m_bl_o=0, mu_o=0, error_o=1.
REQ-018 DONE lasts one cycle, with valid_o=1; next state IDLE.
REQ-019 Latency, with start sampled at the end of cycle C:
  - Success: valid_o=1 in cycle C+2k+3.
  - Error: valid_o=1 in cycle C+2.
REQ-020 m_bl_o, mu_o and error_o SHALL hold their values between completions and change only on entry to DONE.
REQ-021 A start accepted in the IDLE cycle right after DONE SHALL be honoured; back-to-back operation has no dead cycle beyond DONE.
REQ-022 Changes on m_i after capture SHALL NOT affect the result in progress.
REQ-023 busy_o and valid_o SHALL never be high in the same cycle.

Reset
REQ-024 rst_ni=0 SHALL immediately, asynchronously, force the following, in any state including mid-DIVIDE:
  - state IDLE;
  - busy_o=0, valid_o=0, error_o=0, m_bl_o=0, mu_o=0;
  - m_q, counter, remainder and quotient cleared.
REQ-025 After rst_ni deasserts, the block SHALL accept a start on the first clock edge; no result from an aborted operation SHALL ever appear.

Verification
REQ-026 m_i=13 -> k=4: busy_o high 10 cycles, valid_o in cycle C+11, m_bl_o=4, mu_o=19, error_o=0.
REQ-027 m_i=1 -> valid_o at C+5, m_bl_o=1, mu_o=4. m_i=2^61 (DATA_LENGTH=64) -> valid_o at C+127, m_bl_o=62, mu_o=2^63.
REQ-028 m_i=2^62-1 -> m_bl_o=62, mu_o=2^62+1. m_i=0 or m_i=2^62 -> valid_o at C+2, error_o=1, mu_o=0, m_bl_o=0.
REQ-029 Async reset mid-DIVIDE:
  - Run m_i=13.
  - Pulse rst_ni low between clock edges in cycle C+6.
  - Required: outputs zero immediately and no valid_o.
  - Then start with m_i=7 -> mu_o=9, m_bl_o=3.
REQ-030 Start and m_i toggling during busy are ignored. A start in the cycle after DONE gives a correct second result.
  - Sequence m_i=13 then m_i=5.
  - Required: mu_o=19, then mu_o=12.
  - Between completions, the outputs hold 19.
